// File: rtl/la_hsrx.sv
// la_hsrx: destination-side controller for a 4-phase req/ack CDC handshake.
// The request is synchronized through la_dsync; the source-held data bus is
// captured once when the FSM leaves IDLE and offered on a valid/ready port.
// The acknowledge is only raised after the local consumer takes the word.
//
// Ports:
//   clk          destination clock
//   reset        asynchronous active-high reset
//   req_in       asynchronous 4-phase request from the source domain
//   data_in      source data, stable while req_in is high
//   ack_out      registered acknowledge back to the source domain
//   out_valid    captured word available
//   out_ready    local consumer accepts the word
//   out_data     captured word
//   busy         controller is not in IDLE
//   err_timeout  sticky flag: req_in held high too long after ack
//   clr_err      synchronous clear of err_timeout (a same-cycle set wins)
//   xfer_cnt     completed-transfer count, wraps modulo 2^CW

// la_dsync: plain multi-flop level synchronizer with a selectable reset value.
module la_dsync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= {STAGES{RST_VAL}};
    end else begin
      sync[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        sync[i] <= sync[i-1];
      end
    end
  end

  assign q = sync[STAGES-1];

endmodule

module la_hsrx #(
  parameter int unsigned DW      = 8,
  parameter int unsigned STAGES  = 2,
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_in,
  input  logic [DW-1:0] data_in,
  output logic          ack_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          err_timeout,
  input  logic          clr_err,
  output logic [CW-1:0] xfer_cnt
);

  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    DRAIN,
    IDLE,
    VALID,
    ACK
  } state_t;

  state_t          state, state_n;
  logic            req_s;
  logic            ack_n, valid_n, busy_n, err_n;
  logic [DW-1:0]   data_n;
  logic [CW-1:0]   cnt_n;
  logic [TW-1:0]   tcnt, tcnt_n;

  // Synchronizer resets to "request high" so DRAIN only exits once a genuine
  // low has propagated; a stale high req across reset cannot start a transfer.
  la_dsync #(
    .STAGES  (STAGES),
    .RST_VAL (1'b1)
  ) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (req_in),
    .q     (req_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    ack_n   = ack_out;
    valid_n = out_valid;
    data_n  = out_data;
    tcnt_n  = tcnt;
    cnt_n   = xfer_cnt;
    err_n   = err_timeout & ~clr_err;

    case (state)
      DRAIN: begin
        ack_n = 1'b0;
        if (!req_s) state_n = IDLE;
      end
      IDLE: begin
        ack_n = 1'b0;
        if (req_s) begin
          data_n  = data_in;
          valid_n = 1'b1;
          state_n = VALID;
        end
      end
      VALID: begin
        if (out_ready) begin
          valid_n = 1'b0;
          ack_n   = 1'b1;
          tcnt_n  = '0;
          state_n = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          ack_n   = 1'b0;
          cnt_n   = xfer_cnt + CW'(1);
          state_n = IDLE;
        end else if (TIMEOUT != 0 && tcnt != TW'(TIMEOUT)) begin
          // Saturating count; the flag fires only on reaching the limit.
          tcnt_n = tcnt + TW'(1);
          if (tcnt_n == TW'(TIMEOUT)) err_n = 1'b1;
        end
      end
      default: begin
        state_n = DRAIN;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= DRAIN;
      ack_out     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      busy        <= 1'b1;
      err_timeout <= 1'b0;
      xfer_cnt    <= '0;
      tcnt        <= '0;
    end else begin
      state       <= state_n;
      ack_out     <= ack_n;
      out_valid   <= valid_n;
      out_data    <= data_n;
      busy        <= busy_n;
      err_timeout <= err_n;
      xfer_cnt    <= cnt_n;
      tcnt        <= tcnt_n;
    end
  end

endmodule
